// File: rtl/pad_share_arbiter.sv
// Pad-group sharing arbiter: round-robin ownership of NPADS bidirectional
// pads among N_REQ peripherals. Every hand-over passes IDLE and a TA_CYCLES
// turnaround window with all pad output enables low.
// Optional feature macro: PAD_ARB_PREEMPT_EN (bounded hold under contention).
module pad_share_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned NPADS     = 6,
    parameter int unsigned TA_CYCLES = 4,
    parameter int unsigned HOLD_MAX  = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    output logic [N_REQ-1:0]           gnt_o,
    input  logic [N_REQ*NPADS-1:0]     oe_i,
    input  logic [N_REQ*NPADS-1:0]     out_i,
    output logic [NPADS-1:0]           pad_oe_o,
    output logic [NPADS-1:0]           pad_out_o,
    input  logic [NPADS-1:0]           pad_in_i,
    output logic [N_REQ*NPADS-1:0]     in_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       busy_o
);

    localparam int unsigned OW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TA_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    w_owner_nxt;
    logic [OW-1:0]    r_last;
    logic [OW-1:0]    w_last_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [CW-1:0]    r_ta_cnt;
    logic [CW-1:0]    w_ta_nxt;

    logic [OW-1:0]    w_sel;
    logic [OW-1:0]    w_idx;
    logic             w_found;
    logic             w_own;
    logic [NPADS-1:0] w_oe_sel;
    logic [NPADS-1:0] w_out_sel;

`ifdef PAD_ARB_PREEMPT_EN
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_hold_nxt;
    logic             w_other_req;

    // Any requester other than the current owner is waiting
    assign w_other_req = |(req_i & ~r_gnt);
`endif

    // Elaboration-time guard on the legal parameter range
    if (N_REQ < 2 || NPADS < 1 || TA_CYCLES < 1 || HOLD_MAX < 1) begin : g_bad_param
        $error("pad_share_arbiter: illegal parameter value");
    end

    // Round-robin pick: first requester after last_owner in cyclic order.
    // A preempted owner is last_owner, so it naturally loses to any other pending request.
    always_comb begin : rr_select
        w_sel   = r_last;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = OW'((32'(r_last) + k) % N_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next-state and next-register values for the ownership FSM
    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_ta_nxt    = r_ta_cnt;
`ifdef PAD_ARB_PREEMPT_EN
        w_hold_nxt  = r_hold;
`endif
        unique case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                w_ta_nxt  = '0;
                if (|req_i) begin
                    w_state_nxt = ST_TURN;
                    w_owner_nxt = w_sel;
                end
            end
            ST_TURN: begin
                if (!req_i[r_owner]) begin
                    // Abort: selected requester withdrew, last_owner untouched
                    w_state_nxt = ST_IDLE;
                    w_ta_nxt    = '0;
                end else if (r_ta_cnt == CW'(TA_CYCLES - 1)) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = N_REQ'(1) << r_owner;
                    w_last_nxt  = r_owner;
                    w_ta_nxt    = '0;
`ifdef PAD_ARB_PREEMPT_EN
                    w_hold_nxt  = '0;
`endif
                end else begin
                    w_ta_nxt = r_ta_cnt + CW'(1);
                end
            end
            ST_OWN: begin
                if (!req_i[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
`ifdef PAD_ARB_PREEMPT_EN
                else if (w_other_req) begin
                    if (r_hold == HW'(HOLD_MAX - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_ta_nxt    = '0;
            end
        endcase
    end

    // State and bookkeeping registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_last   <= OW'(N_REQ - 1);
            r_gnt    <= '0;
            r_ta_cnt <= '0;
`ifdef PAD_ARB_PREEMPT_EN
            r_hold   <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ta_cnt <= w_ta_nxt;
`ifdef PAD_ARB_PREEMPT_EN
            r_hold   <= w_hold_nxt;
`endif
        end
    end

    // Select the owner's enable/data slice
    always_comb begin : pad_mux
        w_oe_sel  = '0;
        w_out_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_oe_sel  = oe_i[i*NPADS +: NPADS];
                w_out_sel = out_i[i*NPADS +: NPADS];
            end
        end
    end

    // Route pad inputs only to the owner, only while it owns the group
    always_comb begin : in_gate
        in_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_own && (r_owner == OW'(i))) begin
                in_o[i*NPADS +: NPADS] = pad_in_i;
            end
        end
    end

    assign w_own     = (r_state == ST_OWN);
    // Undriven pads also carry zero data so nothing toggles behind a low OE
    assign pad_oe_o  = w_own ? w_oe_sel : '0;
    assign pad_out_o = w_own ? (w_out_sel & w_oe_sel) : '0;
    assign gnt_o     = r_gnt;
    assign owner_o   = r_owner;
    assign busy_o    = (r_state != ST_IDLE);

endmodule
